// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-addressed data memory with a combinational read port.
// Handles byte/half/word accesses with lane extraction, sign/zero extension and read-modify-write.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam logic [ADDR_W-1:0] MemWordsA = ADDR_W'(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StAccess, StMerge} state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       merge_q, merge_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [ADDR_W-1:0] req_word_idx;
  logic [ADDR_W-1:0] word_idx_q;
  logic              req_err;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign req_word_idx = {2'b00, req_addr[ADDR_W-1:2]};
  assign word_idx_q   = {2'b00, addr_q[ADDR_W-1:2]};

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_word_idx >= MemWordsA) req_err = 1'b1;
  end

  // Lane extraction for loads.
  always_comb begin
    load_byte = 8'h00;
    unique case (addr_q[1:0])
      2'd0: load_byte = mem_read_data[7:0];
      2'd1: load_byte = mem_read_data[15:8];
      2'd2: load_byte = mem_read_data[23:16];
      2'd3: load_byte = mem_read_data[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    if (size_q == 2'b00) begin
      load_data = {{24{signed_q & load_byte[7]}}, load_byte};
    end else if (size_q == 2'b01) begin
      load_data = {{16{signed_q & load_half[15]}}, load_half};
    end else begin
      load_data = mem_read_data;
    end
  end

  // Sub-word store: replace the target lane in the word just read.
  always_comb begin
    merged = mem_read_data;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_read_data;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    size_d         = size_q;
    signed_d       = signed_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    merge_d        = merge_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    req_ready      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = 32'h0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_err;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        mem_address = word_idx_q;
        if (err_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 32'h0;
          state_d     = StIdle;
        end else if (!write_q) begin
          mem_read    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = load_data;
          state_d     = StIdle;
        end else if (size_q == 2'b10) begin
          mem_write      = 1'b1;
          mem_write_data = wdata_q;
          rsp_valid_d    = 1'b1;
          rsp_err_d      = 1'b0;
          rsp_data_d     = 32'h0;
          state_d        = StIdle;
        end else begin
          mem_read = 1'b1;
          merge_d  = merged;
          state_d  = StMerge;
        end
      end
      StMerge: begin
        mem_address    = word_idx_q;
        mem_write      = 1'b1;
        mem_write_data = merge_q;
        rsp_valid_d    = 1'b1;
        rsp_err_d      = 1'b0;
        rsp_data_d     = 32'h0;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // No memory traffic while reset is asserted, even mid-operation.
    if (rst) begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_write_data = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      merge_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      merge_q     <= merge_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
